// File: rtl/seg_scan_ctrl.sv
// Multiplexed seven-segment controller: memory-mapped value/mode registers, hex or
// decimal (double-dabble) display, blanking, decimal points and leading-zero suppression.
module seg_scan_ctrl #(
  parameter int DIGITS   = 8,
  parameter int DATA_W   = 32,
  parameter int SCAN_DIV = 100000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic              wr_addr,
  input  logic [31:0]       wr_data,
  output logic              busy,
  output logic [7:0]        segment_led,
  output logic [DIGITS-1:0] seg_en
);

  localparam int BCD_N  = (DATA_W * 3) / 10 + 1;
  localparam int BCD_W  = BCD_N * 4;
  localparam int DISP_W = DIGITS * 4;
  localparam int HEX_W  = (DATA_W > DISP_W) ? DATA_W : DISP_W;
  localparam int BX_W   = (BCD_W > DISP_W) ? BCD_W : DISP_W;
  localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int PRE_W  = $clog2(SCAN_DIV);
  localparam int CNT_W  = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t              state_reg, state_next;
  logic                load_bcd;
  logic [DATA_W-1:0]   val_reg, sh_reg, conv_src;
  logic                dec_reg, lz_reg, hex_load_reg, ovf_reg;
  logic [DIGITS-1:0]   blank_reg, dp_reg, keep;
  logic [BCD_W-1:0]    bcd_reg, bcd_adj;
  logic [CNT_W-1:0]    cnt_reg;
  logic [DISP_W-1:0]   disp_reg;
  logic [IDX_W-1:0]    idx_reg;
  logic [PRE_W-1:0]    pre_reg;
  logic [HEX_W-1:0]    val_ext;
  logic [BX_W-1:0]     bcd_ext;
  logic                val_wr, mode_wr, dec_new, start_dec, start_hex, ovf_calc;
  logic [3:0]          cur_nib;
  logic                cur_off;
  logic [7:0]          seg_next;
  logic [DIGITS-1:0]   en_next;

  // A write's effect depends on the mode in force after that same write.
  assign val_wr    = wr_en & ~wr_addr;
  assign mode_wr   = wr_en & wr_addr;
  assign dec_new   = mode_wr ? wr_data[0] : dec_reg;
  assign start_dec = wr_en & dec_new;
  assign start_hex = wr_en & ~dec_new;
  assign conv_src  = val_wr ? wr_data[DATA_W-1:0] : val_reg;
  assign busy      = (state_reg == S_SHIFT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      val_reg      <= '0;
      dec_reg      <= 1'b0;
      lz_reg       <= 1'b0;
      blank_reg    <= '0;
      dp_reg       <= '0;
      hex_load_reg <= 1'b0;
    end else begin
      if (val_wr) val_reg <= wr_data[DATA_W-1:0];
      if (mode_wr) begin
        dec_reg   <= wr_data[0];
        lz_reg    <= wr_data[1];
        blank_reg <= wr_data[8 +: DIGITS];
        dp_reg    <= wr_data[16 +: DIGITS];
      end
      hex_load_reg <= start_hex;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= S_IDLE;
    else        state_reg <= state_next;
  end

  // Any new write overrides whatever the converter is doing, including a pending DONE load.
  always_comb begin
    state_next = state_reg;
    load_bcd   = 1'b0;
    if (start_dec) begin
      state_next = S_SHIFT;
    end else if (start_hex) begin
      state_next = S_IDLE;
    end else begin
      case (state_reg)
        S_SHIFT: if (cnt_reg == CNT_W'(DATA_W - 1)) state_next = S_DONE;
        S_DONE: begin
          load_bcd   = 1'b1;
          state_next = S_IDLE;
        end
        default: state_next = S_IDLE;
      endcase
    end
  end

  generate
    for (genvar gi = 0; gi < BCD_N; gi++) begin : g_dabble
      assign bcd_adj[gi*4 +: 4] = (bcd_reg[gi*4 +: 4] >= 4'd5) ?
                                  bcd_reg[gi*4 +: 4] + 4'd3 : bcd_reg[gi*4 +: 4];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_reg  <= '0;
      bcd_reg <= '0;
      cnt_reg <= '0;
    end else if (start_dec) begin
      sh_reg  <= conv_src;
      bcd_reg <= '0;
      cnt_reg <= '0;
    end else if (state_reg == S_SHIFT) begin
      bcd_reg <= {bcd_adj[BCD_W-2:0], sh_reg[DATA_W-1]};
      sh_reg  <= {sh_reg[DATA_W-2:0], 1'b0};
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign val_ext  = HEX_W'(val_reg);
  assign bcd_ext  = BX_W'(bcd_reg);
  assign ovf_calc = |(bcd_ext >> DISP_W);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disp_reg <= '0;
      ovf_reg  <= 1'b0;
    end else if (hex_load_reg) begin
      disp_reg <= val_ext[DISP_W-1:0];
      ovf_reg  <= 1'b0;
    end else if (load_bcd) begin
      disp_reg <= bcd_ext[DISP_W-1:0];
      ovf_reg  <= ovf_calc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_reg <= '0;
      idx_reg <= '0;
    end else if (pre_reg == PRE_W'(SCAN_DIV - 1)) begin
      pre_reg <= '0;
      idx_reg <= (idx_reg == IDX_W'(DIGITS - 1)) ? '0 : idx_reg + 1'b1;
    end else begin
      pre_reg <= pre_reg + 1'b1;
    end
  end

  // A digit stays lit if it or any digit above it is nonzero; digit 0 always stays.
  always_comb begin
    logic seen;
    seen = 1'b0;
    keep = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      seen    = seen | (disp_reg[i*4 +: 4] != 4'd0);
      keep[i] = seen | (i == 0);
    end
  end

  function automatic logic [7:0] hex_code(input logic [3:0] n);
    case (n)
      4'h0: hex_code = 8'hC0;  4'h1: hex_code = 8'hF9;
      4'h2: hex_code = 8'hA4;  4'h3: hex_code = 8'hB0;
      4'h4: hex_code = 8'h99;  4'h5: hex_code = 8'h92;
      4'h6: hex_code = 8'h82;  4'h7: hex_code = 8'hF8;
      4'h8: hex_code = 8'h80;  4'h9: hex_code = 8'h90;
      4'hA: hex_code = 8'h88;  4'hB: hex_code = 8'h83;
      4'hC: hex_code = 8'hC6;  4'hD: hex_code = 8'hA1;
      4'hE: hex_code = 8'h86;  default: hex_code = 8'h8E;
    endcase
  endfunction

  always_comb begin
    cur_nib  = disp_reg[idx_reg*4 +: 4];
    cur_off  = blank_reg[idx_reg] | (lz_reg & ~ovf_reg & ~keep[idx_reg]);
    seg_next = ovf_reg ? 8'hBF : hex_code(cur_nib);
    if (dp_reg[idx_reg]) seg_next[7] = 1'b0;
    en_next  = cur_off ? '1 : ~(DIGITS'(1) << idx_reg);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      segment_led <= 8'hC0;
      seg_en      <= ~DIGITS'(1);
    end else begin
      segment_led <= seg_next;
      seg_en      <= en_next;
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl (8 digits, 32-bit value, SCAN_DIV=4) with
// hand-computed segment codes and a small scan-position model for synchronisation.
module tb_seg_scan_ctrl;

  logic        clk, rst_n, wr_en, wr_addr;
  logic [31:0] wr_data;
  logic        busy;
  logic [7:0]  segment_led;
  logic [7:0]  seg_en;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] seg_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                               8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
  logic [7:0] exp_dec [8];

  seg_scan_ctrl #(.DIGITS(8), .DATA_W(32), .SCAN_DIV(4)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .segment_led(segment_led), .seg_en(seg_en)
  );

  always #5 clk = ~clk;

  // Which digit the pins currently show: scan position delayed by the output register.
  int m_pre, m_idx, pin_idx;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pre <= 0; m_idx <= 0; pin_idx <= 0;
    end else begin
      pin_idx <= m_idx;
      if (m_pre == 3) begin
        m_pre <= 0;
        m_idx <= (m_idx + 1) % 8;
      end else begin
        m_pre <= m_pre + 1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic addr, input logic [31:0] data);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = addr; wr_data = data;
    @(negedge clk);
    wr_en = 1'b0;
    $display("write addr=%0d data=%h", addr, data);
  endtask

  task automatic wait_digit(input int i);
    int k;
    k = 0;
    while (pin_idx == i && k < 80) begin @(negedge clk); k++; end
    while (pin_idx != i && k < 80) begin @(negedge clk); k++; end
    check("wait_digit", 32'(k < 80), 32'd1);
  endtask

  task automatic show(input string tag, input int i, input logic [7:0] seg, input logic [7:0] en);
    wait_digit(i);
    check({tag, "_seg"}, segment_led, seg);
    check({tag, "_en"}, seg_en, en);
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (busy !== 1'b0 && k < 200) begin @(negedge clk); k++; end
    check("wait_idle", busy, 1'b0);
  endtask

  task automatic busy_len(input string tag, input int exp_len);
    int k;
    k = 0;
    while (busy === 1'b1 && k < 100) begin k++; @(negedge clk); end
    check(tag, k, exp_len);
  endtask

  initial begin
    int v;
    clk = 0; rst_n = 1; wr_en = 0; wr_addr = 0; wr_data = 0;
    v = 12345678;
    for (int i = 0; i < 8; i++) begin
      exp_dec[i] = seg_tab[v % 10];
      v = v / 10;
    end

    #1 rst_n = 0;
    repeat (3) @(negedge clk);
    check("rst_seg", segment_led, 8'hC0);
    check("rst_en", seg_en, 8'hFE);
    check("rst_busy", busy, 1'b0);
    rst_n = 1;

    // Hex scan of 0x1234ABCD
    wr(1'b0, 32'h1234ABCD);
    repeat (2) @(negedge clk);
    begin
      logic [31:0] hv;
      hv = 32'h1234ABCD;
      for (int i = 0; i < 8; i++)
        show("hex", i, seg_tab[hv[i*4 +: 4]], ~(8'd1 << i));
    end
    wait_digit(7);
    check("hold7_0", seg_en, 8'h7F);
    for (int c = 1; c < 4; c++) begin
      @(negedge clk);
      check("hold7", seg_en, 8'h7F);
    end
    @(negedge clk);
    check("wrap_en", seg_en, 8'hFE);
    check("wrap_seg", segment_led, 8'hA1);

    // Decimal: 0x1234ABCD overflows eight digits first, then 12345678
    wr(1'b1, 32'h1);
    wait_idle();
    repeat (2) @(negedge clk);
    wr(1'b0, 32'd12345678);
    busy_len("dec_busy_len", 32);
    check("dec_lat_old0", segment_led, 8'hBF);
    @(negedge clk);
    check("dec_lat_old1", segment_led, 8'hBF);
    @(negedge clk);
    check("dec_lat_new", segment_led, exp_dec[pin_idx]);
    for (int i = 0; i < 8; i++)
      show("dec", i, exp_dec[i], ~(8'd1 << i));

    // Leading-zero suppression
    wr(1'b1, 32'h3);
    wait_idle();
    wr(1'b0, 32'd42);
    wait_idle();
    repeat (2) @(negedge clk);
    show("lz0", 0, 8'hA4, 8'hFE);
    show("lz1", 1, 8'h99, 8'hFD);
    wait_digit(2);
    check("lz2_en", seg_en, 8'hFF);
    wait_digit(7);
    check("lz7_en", seg_en, 8'hFF);

    // Overflow
    wr(1'b0, 32'd123456789);
    wait_idle();
    repeat (2) @(negedge clk);
    show("ovf0", 0, 8'hBF, 8'hFE);
    show("ovf5", 5, 8'hBF, 8'hDF);

    // Restart: second write after ten busy cycles wins
    wr(1'b0, 32'd5);
    repeat (8) @(negedge clk);
    check("rs_busy_mid", busy, 1'b1);
    wr(1'b0, 32'd7);
    busy_len("rs_busy_len", 32);
    repeat (2) @(negedge clk);
    show("rs0", 0, 8'hF8, 8'hFE);
    wait_digit(1);
    check("rs1_en", seg_en, 8'hFF);

    // Blank mask 0x0F in hex mode (val = 7)
    wr(1'b1, 32'h0000_0F00);
    repeat (2) @(negedge clk);
    wait_digit(0);
    check("blk0_en", seg_en, 8'hFF);
    wait_digit(3);
    check("blk3_en", seg_en, 8'hFF);
    show("blk4", 4, 8'hC0, 8'hEF);

    // dp mask 0x01
    wr(1'b1, 32'h0001_0000);
    repeat (2) @(negedge clk);
    show("dp0", 0, 8'h78, 8'hFE);
    show("dp1", 1, 8'hC0, 8'hFD);

    // Asynchronous reset in the middle of a conversion
    wr(1'b1, 32'h1);
    repeat (3) @(negedge clk);
    check("ar_busy_pre", busy, 1'b1);
    #2 rst_n = 0;
    #1;
    check("ar_busy", busy, 1'b0);
    check("ar_seg", segment_led, 8'hC0);
    check("ar_en", seg_en, 8'hFE);
    @(negedge clk);
    rst_n = 1;
    repeat (2) @(negedge clk);
    check("ar_busy_after", busy, 1'b0);
    wr(1'b1, 32'h0);
    repeat (2) @(negedge clk);
    show("ar_val0", 0, 8'hC0, 8'hFE);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
